demux_16w_1_to_8_reg: RTL and testbench

- Registered 1-to-8 demultiplexer. It is the write-side counterpart of the 8-to-1 read mux.
- Routes one WIDTH-bit input word to one of eight holding registers R..Y, chosen by select bits S2,S1,S0.
- Outputs R..Y feed directly into the 8-to-1 mux inputs, forming the datapath register bank write port.
- Adds per-lane write strobes, sticky valid flags, a broadcast write, and a one-cycle write acknowledge.

---
 rtl/proj_b_pkg.sv | 22 ++
 rtl/demux_lane_reg.sv | 25 ++
 rtl/demux_16w_1_to_8_reg.sv | 73 +++++++
 tb/tb_demux_16w_1_to_8_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/proj_b_pkg.sv
// Shared definitions for the register-bank write demux and its companion read mux.
package proj_b_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned NUM_LANES     = 8;

  typedef enum logic [2:0] {
    LANE_R = 3'd0,
    LANE_S = 3'd1,
    LANE_T = 3'd2,
    LANE_U = 3'd3,
    LANE_V = 3'd4,
    LANE_W = 3'd5,
    LANE_X = 3'd6,
    LANE_Y = 3'd7
  } lane_sel_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t s);
    lane_onehot = NUM_LANES'(1) << s;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One holding register of the bank: load-enabled storage plus a one-cycle load pulse.
module demux_lane_reg
  import proj_b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pulse
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= load;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/demux_16w_1_to_8_reg.sv
// Registered 1-to-8 demux: write port of the lane register bank with strobes, valid flags and ack.
module demux_16w_1_to_8_reg
  import proj_b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     D,
  input  logic                 S0,
  input  logic                 S1,
  input  logic                 S2,
  input  logic                 WrEn,
  input  logic                 Bcast,
  input  logic                 ClrValid,
  output logic [WIDTH-1:0]     R,
  output logic [WIDTH-1:0]     S,
  output logic [WIDTH-1:0]     T,
  output logic [WIDTH-1:0]     U,
  output logic [WIDTH-1:0]     V,
  output logic [WIDTH-1:0]     W,
  output logic [WIDTH-1:0]     X,
  output logic [WIDTH-1:0]     Y,
  output logic [NUM_LANES-1:0] Strobe,
  output logic [NUM_LANES-1:0] Valid,
  output logic                 Ack
);

  lane_sel_t            sel;
  logic [NUM_LANES-1:0] wmask;
  logic [WIDTH-1:0]     q [NUM_LANES];

  assign sel = lane_sel_t'({S2, S1, S0});

  // Broadcast overrides the single-lane request; select is ignored then.
  always_comb begin
    wmask = '0;
    if (Bcast)     wmask = '1;
    else if (WrEn) wmask = lane_onehot(sel);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk   (Clk),
      .rst   (Reset),
      .load  (wmask[i]),
      .d     (D),
      .q     (q[i]),
      .pulse (Strobe[i])
    );
  end

  // Clear drops every flag, then this cycle's written lanes are re-set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Valid <= '0;
      Ack   <= 1'b0;
    end else begin
      Valid <= (ClrValid ? '0 : Valid) | wmask;
      Ack   <= |wmask;
    end
  end

  assign R = q[0];
  assign S = q[1];
  assign T = q[2];
  assign U = q[3];
  assign V = q[4];
  assign W = q[5];
  assign X = q[6];
  assign Y = q[7];

endmodule

// File: tb/tb_demux_16w_1_to_8_reg.sv
// Directed table-driven bench for the registered 1-to-8 write demux.
module tb_demux_16w_1_to_8_reg;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] D = '0;
  logic        S0 = 1'b0, S1 = 1'b0, S2 = 1'b0;
  logic        WrEn = 1'b0, Bcast = 1'b0, ClrValid = 1'b0;
  logic [15:0] R, S, T, U, V, W, X, Y;
  logic [7:0]  Strobe, Valid;
  logic        Ack;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] lanes [8];
  assign lanes[0] = R;
  assign lanes[1] = S;
  assign lanes[2] = T;
  assign lanes[3] = U;
  assign lanes[4] = V;
  assign lanes[5] = W;
  assign lanes[6] = X;
  assign lanes[7] = Y;

  demux_16w_1_to_8_reg #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .D(D), .S0(S0), .S1(S1), .S2(S2),
    .WrEn(WrEn), .Bcast(Bcast), .ClrValid(ClrValid),
    .R(R), .S(S), .T(T), .U(U), .V(V), .W(W), .X(X), .Y(Y),
    .Strobe(Strobe), .Valid(Valid), .Ack(Ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic        bc;
    logic        clr;
    logic [2:0]  sel;
    logic [15:0] d;
    logic [7:0]  e_strobe;
    logic        e_ack;
    logic [7:0]  e_valid;
    int unsigned chk_lane;
    logic [15:0] e_lane;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic bc, logic clr, logic [2:0] sel, logic [15:0] d,
                              logic [7:0] es, logic ea, logic [7:0] ev,
                              int unsigned cl, logic [15:0] el);
    vec_t v;
    v.wr = wr; v.bc = bc; v.clr = clr; v.sel = sel; v.d = d;
    v.e_strobe = es; v.e_ack = ea; v.e_valid = ev; v.chk_lane = cl; v.e_lane = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic bc, input logic clr,
                       input logic [2:0] sel, input logic [15:0] d);
    WrEn = wr; Bcast = bc; ClrValid = clr;
    {S2, S1, S0} = sel; D = d;
  endtask

  task automatic step(input logic wr, input logic bc, input logic clr,
                      input logic [2:0] sel, input logic [15:0] d);
    @(negedge Clk);
    drive(wr, bc, clr, sel, d);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Sweep: D = 16'h1111*(sel+1)
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 3'(i), 16'(16'h1111 * (i + 1)),
                        8'(1 << i), 1, 8'((2 << i) - 1), i, 16'(16'h1111 * (i + 1))));
    // Bcast wins over WrEn
    vecs.push_back(mk(1, 1, 0, 3'd3, 16'hA5A5, 8'hFF, 1, 8'hFF, 0, 16'hA5A5));
    // Idle hold with moving select and data
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 3'(7 - i), 16'(16'h0F0F ^ (i * 16'h1357)),
                        8'h00, 0, 8'hFF, 7 - i, 16'hA5A5));
    // Clear racing a write: write wins for its own bit
    vecs.push_back(mk(1, 0, 1, 3'd5, 16'h1234, 8'h20, 1, 8'h20, 5, 16'h1234));
    // Clear alone: data untouched
    vecs.push_back(mk(0, 0, 1, 3'd5, 16'hDEAD, 8'h00, 0, 8'h00, 5, 16'h1234));

    // Asynchronous reset from power-up
    #2 Reset = 1'b1;
    #1;
    chk("por_valid", 32'(Valid), 32'h0);
    chk("por_ack", 32'(Ack), 32'h0);
    chk("por_strobe", 32'(Strobe), 32'h0);
    chk("por_lane0", 32'(R), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].bc, vecs[i].clr, vecs[i].sel, vecs[i].d);
      chk($sformatf("v%0d_strobe", i), 32'(Strobe), 32'(vecs[i].e_strobe));
      chk($sformatf("v%0d_ack", i), 32'(Ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_valid", i), 32'(Valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_lane%0d", i, vecs[i].chk_lane),
          32'(lanes[vecs[i].chk_lane]), 32'(vecs[i].e_lane));
      if (i == 7)
        for (int j = 0; j < 8; j++)
          chk($sformatf("sweep_lane%0d", j), 32'(lanes[j]), 32'(16'h1111 * (j + 1)));
      if (i == 8)
        for (int j = 0; j < 8; j++)
          chk($sformatf("bcast_lane%0d", j), 32'(lanes[j]), 32'hA5A5);
    end

    // Loop-back through a read mux, one cycle after each write, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 3'(i), 16'(16'hC000 + i * 16'h0101));
      chk($sformatf("mux_sel%0d", i), 32'(lanes[{S2, S1, S0}]), 32'(16'hC000 + i * 16'h0101));
      chk($sformatf("b2b_ack%0d", i), 32'(Ack), 32'h1);
    end

    // Mid-cycle reset cancels a pending strobe/ack immediately
    #2 Reset = 1'b1;
    #1;
    chk("rst_strobe", 32'(Strobe), 32'h0);
    chk("rst_ack", 32'(Ack), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    for (int j = 0; j < 8; j++)
      chk($sformatf("rst_lane%0d", j), 32'(lanes[j]), 32'h0);

    // A write held during reset must not land
    step(1, 0, 0, 3'd2, 16'hFFFF);
    chk("rst_hold_lane2", 32'(T), 32'h0);
    chk("rst_hold_strobe", 32'(Strobe), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(0, 0, 0, 3'd0, 16'h0);
    @(posedge Clk);
    #1;
    chk("post_rst_lane2", 32'(T), 32'h0);
    chk("post_rst_ack", 32'(Ack), 32'h0);
    chk("post_rst_valid", 32'(Valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
